// File: rtl/move_sequencer_pkg.sv
// Shared move codes, FSM state encoding and timer width for the move sequencer.
package move_sequencer_pkg;

  typedef logic [2:0] mv_t;

  localparam mv_t MV_SPAWN = 3'd0;
  localparam mv_t MV_LEFT  = 3'd1;
  localparam mv_t MV_RIGHT = 3'd2;
  localparam mv_t MV_ROT   = 3'd3;
  localparam mv_t MV_DOWN  = 3'd4;

  // Wide enough for both timeouts; the counter may wrap harmlessly while not waiting.
  localparam int TMR_W = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SPAWN_ISSUE,
    ST_SPAWN_CHK,
    ST_WAIT_SPAWN,
    ST_READY,
    ST_ISSUE,
    ST_WAIT,
    ST_LOCK,
    ST_CLEAR,
    ST_OVER
  } state_t;

  function automatic logic is_busy(input state_t s);
    return !(s inside {ST_IDLE, ST_READY, ST_OVER});
  endfunction

endpackage

// File: rtl/move_sequencer_if.sv
// Checker and grid handshake bundle; master = sequencer, slave = checker/grid side.
interface move_sequencer_if;
  import move_sequencer_pkg::*;

  logic req_valid;
  mv_t  req_move;
  logic chk_done;
  logic chk_ok;
  logic lock;
  logic grid_ready;
  logic spawn;

  modport master (
    output req_valid, req_move, lock, spawn,
    input  chk_done, chk_ok, grid_ready
  );

  modport slave (
    input  req_valid, req_move, lock, spawn,
    output chk_done, chk_ok, grid_ready
  );

endinterface

// File: rtl/move_sequencer_req_arbiter.sv
// Pending-request latches plus fixed-priority pick (DOWN > ROT > LEFT > RIGHT).
// Grant and winner clear are combinational; a new request always beats a same-cycle clear.
module move_sequencer_req_arbiter
  import move_sequencer_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic latch_en_i,
  input  logic left_i,
  input  logic right_i,
  input  logic rotate_i,
  input  logic tick_i,
  input  logic drop_i,
  input  logic clr_all_i,
  input  logic clr_drop_i,
  input  logic arb_en_i,
  output logic grant_vld_o,
  output mv_t  grant_move_o
);

  logic left_q, right_q, rot_q, tick_q, drop_q;
  logic left_d, right_d, rot_d, tick_d, drop_d;
  logic clr_left, clr_right, clr_rot, clr_tick;

  always_comb begin
    grant_vld_o  = 1'b0;
    grant_move_o = MV_DOWN;
    clr_left     = 1'b0;
    clr_right    = 1'b0;
    clr_rot      = 1'b0;
    clr_tick     = 1'b0;
    if (arb_en_i) begin
      if (tick_q || drop_q) begin
        grant_vld_o = 1'b1;
        clr_tick    = 1'b1;
      end else if (rot_q) begin
        grant_vld_o  = 1'b1;
        grant_move_o = MV_ROT;
        clr_rot      = 1'b1;
      end else if (left_q && right_q) begin
        // Opposing moves cancel: drop both, spend the cycle without a transaction.
        clr_left  = 1'b1;
        clr_right = 1'b1;
      end else if (left_q) begin
        grant_vld_o  = 1'b1;
        grant_move_o = MV_LEFT;
        clr_left     = 1'b1;
      end else if (right_q) begin
        grant_vld_o  = 1'b1;
        grant_move_o = MV_RIGHT;
        clr_right    = 1'b1;
      end
    end

    left_d  = (latch_en_i & left_i)   | (left_q  & ~(clr_left  | clr_all_i));
    right_d = (latch_en_i & right_i)  | (right_q & ~(clr_right | clr_all_i));
    rot_d   = (latch_en_i & rotate_i) | (rot_q   & ~(clr_rot   | clr_all_i));
    tick_d  = (latch_en_i & tick_i)   | (tick_q  & ~(clr_tick  | clr_all_i));
    drop_d  = (latch_en_i & drop_i)   | (drop_q  & ~(clr_drop_i | clr_all_i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      left_q  <= 1'b0;
      right_q <= 1'b0;
      rot_q   <= 1'b0;
      tick_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      left_q  <= left_d;
      right_q <= right_d;
      rot_q   <= rot_d;
      tick_q  <= tick_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: rtl/move_sequencer.sv
// Game controller: spawn -> move/check -> lock -> line clear -> spawn, one checker transaction at a time.
// Pending request reaches req_valid in 2 cycles; chk_done/grid_ready are waited on with timeouts.
module move_sequencer
  import move_sequencer_pkg::*;
#(
  parameter int CHK_TIMEOUT  = 32,
  parameter int GRID_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              left_i,
  input  logic              right_i,
  input  logic              rotate_i,
  input  logic              tick_i,
  input  logic              drop_i,
  move_sequencer_if.master  bus,
  output logic              game_over_o,
  output logic              busy_o,
  output logic              err_o
);

  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  mv_t              req_move_q, req_move_d;
  logic             grant_vld;
  mv_t              grant_move;
  logic             chk_to, grid_to;

  assign chk_to  = (tmr_q == TMR_W'(CHK_TIMEOUT - 1));
  assign grid_to = (tmr_q == TMR_W'(GRID_TIMEOUT - 1));

  move_sequencer_req_arbiter u_arb (
    .clk          (clk),
    .rst          (rst),
    .latch_en_i   (!(state_q inside {ST_IDLE, ST_OVER})),
    .left_i       (left_i),
    .right_i      (right_i),
    .rotate_i     (rotate_i),
    .tick_i       (tick_i),
    .drop_i       (drop_i),
    .clr_all_i    (state_d == ST_SPAWN_ISSUE),
    .clr_drop_i   (state_q == ST_LOCK),
    .arb_en_i     (state_q == ST_READY),
    .grant_vld_o  (grant_vld),
    .grant_move_o (grant_move)
  );

  always_comb begin
    state_d    = state_q;
    req_move_d = req_move_q;
    case (state_q)
      ST_IDLE:        state_d = ST_IDLE;
      ST_SPAWN_ISSUE: begin
        state_d    = ST_SPAWN_CHK;
        req_move_d = MV_SPAWN;
      end
      ST_SPAWN_CHK:   state_d = ST_WAIT_SPAWN;
      ST_WAIT_SPAWN: begin
        if (chk_to)             state_d = ST_READY;
        else if (bus.chk_done)  state_d = bus.chk_ok ? ST_READY : ST_OVER;
      end
      ST_READY: begin
        if (grant_vld) begin
          state_d    = ST_ISSUE;
          req_move_d = grant_move;
        end
      end
      ST_ISSUE:       state_d = ST_WAIT;
      ST_WAIT: begin
        if (chk_to) state_d = ST_READY;
        else if (bus.chk_done)
          state_d = (!bus.chk_ok && req_move_q == MV_DOWN) ? ST_LOCK : ST_READY;
      end
      ST_LOCK:        state_d = ST_CLEAR;
      ST_CLEAR: begin
        if (grid_to || bus.grid_ready) state_d = ST_SPAWN_ISSUE;
      end
      ST_OVER:        state_d = ST_OVER;
      default:        state_d = ST_IDLE;
    endcase
    // start overrides any in-flight result arriving in the same cycle
    if (start_i) state_d = ST_SPAWN_ISSUE;
    tmr_d = (state_d != state_q) ? '0 : tmr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tmr_q      <= '0;
      req_move_q <= MV_SPAWN;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      req_move_q <= req_move_d;
    end
  end

  assign bus.req_valid = (state_q == ST_SPAWN_CHK) || (state_q == ST_ISSUE);
  assign bus.req_move  = req_move_q;
  assign bus.lock      = (state_q == ST_LOCK);
  assign bus.spawn     = (state_q == ST_SPAWN_ISSUE);
  assign game_over_o   = (state_q == ST_OVER);
  assign busy_o        = is_busy(state_q);
  assign err_o         = ((state_q == ST_WAIT || state_q == ST_WAIT_SPAWN) && chk_to)
                       || (state_q == ST_CLEAR && grid_to);

endmodule
